// File: rtl/serial_parity_checker.sv
// Receive-side framed serial parity checker: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Optional saturating error counter is enabled by defining PARITY_ERR_CNT_EN.
module serial_parity_checker #(
    parameter int DATA_W     = 3,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            acc_q      <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Pulses default low every cycle, so they last one clk regardless of bit_en.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_d   = PARITY_ODD;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = rx;
                    acc_d          = acc_q ^ rx;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    acc_d   = acc_q ^ rx;
                    state_d = STOP;
                end
                STOP: begin
                    if (rx) begin
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                        perr_d     = acc_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts together with the pulse so err_cnt already includes the error it accompanies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if ((perr_d || ferr_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: an even-parity and an odd-parity checker see the same frames (odd one gets the inverted parity bit).
// Expected results are queued as frames are sent; negedge monitors pop and compare on every pulse.
module tb_serial_parity_checker;

    logic       clk;
    logic       rst_n;
    logic       bit_en;
    logic       rxE, rxO;
    logic [2:0] doE, doO;
    logic       dvE, dvO, peE, peO, feE, feO, bsE, bsO;
    logic [7:0] ecE, ecO;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [2:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t qE[$];
    exp_t qO[$];
    exp_t eE, eO;
    logic [2:0] lastData;
    int         expCnt;

    serial_parity_checker #(.DATA_W(3), .PARITY_ODD(1'b0)) dutEven (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rxE),
        .data_out(doE), .data_valid(dvE), .parity_err(peE), .frame_err(feE),
        .busy(bsE), .err_cnt(ecE)
    );

    serial_parity_checker #(.DATA_W(3), .PARITY_ODD(1'b1)) dutOdd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rxO),
        .data_out(doO), .data_valid(dvO), .parity_err(peO), .frame_err(feO),
        .busy(bsO), .err_cnt(ecO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expCntField();
`ifdef PARITY_ERR_CNT_EN
        return 8'(expCnt);
`else
        return 8'd0;
`endif
    endfunction

    task automatic sendBit(input logic bE, input logic bO, input int gap);
        rxE    = bE;
        rxO    = bO;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        rxE    = 1'b1;
        rxO    = 1'b1;
        for (int i = 1; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] d, input logic p, input logic stopBit, input int gap);
        exp_t e;
        sendBit(1'b0, 1'b0, gap);
        for (int i = 0; i < 3; i++) begin
            sendBit(d[i], d[i], gap);
        end
        sendBit(p, ~p, gap);
        if (stopBit) begin
            e.ferr   = 1'b0;
            e.perr   = (^d) ^ p;
            e.data   = d;
            lastData = d;
        end else begin
            e.ferr = 1'b1;
            e.perr = 1'b0;
            e.data = lastData;
        end
        if ((e.ferr || e.perr) && expCnt < 255) begin
            expCnt++;
        end
        e.cnt = expCntField();
        qE.push_back(e);
        qO.push_back(e);
        sendBit(stopBit, stopBit, gap);
        checkOutput("busyAfterStop.even", 16'(bsE), 16'd0);
        checkOutput("busyAfterStop.odd", 16'(bsO), 16'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".even.data_out"}, 16'(doE), 16'd0);
        checkOutput({tag, ".odd.data_out"}, 16'(doO), 16'd0);
        checkOutput({tag, ".even.pulses"}, 16'({dvE, peE, feE}), 16'd0);
        checkOutput({tag, ".odd.pulses"}, 16'({dvO, peO, feO}), 16'd0);
        checkOutput({tag, ".even.busy"}, 16'(bsE), 16'd0);
        checkOutput({tag, ".odd.busy"}, 16'(bsO), 16'd0);
        checkOutput({tag, ".even.err_cnt"}, 16'(ecE), 16'd0);
        checkOutput({tag, ".odd.err_cnt"}, 16'(ecO), 16'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (dvE || peE || feE)) begin
            if (qE.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL even.unexpectedPulse: got dv=%0b pe=%0b fe=%0b expected none", dvE, peE, feE);
            end else begin
                eE = qE.pop_front();
                checkOutput("even.data_valid", 16'(dvE), 16'(!eE.ferr));
                checkOutput("even.parity_err", 16'(peE), 16'(eE.perr));
                checkOutput("even.frame_err", 16'(feE), 16'(eE.ferr));
                checkOutput("even.data_out", 16'(doE), 16'(eE.data));
                checkOutput("even.err_cnt", 16'(ecE), 16'(eE.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (dvO || peO || feO)) begin
            if (qO.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL odd.unexpectedPulse: got dv=%0b pe=%0b fe=%0b expected none", dvO, peO, feO);
            end else begin
                eO = qO.pop_front();
                checkOutput("odd.data_valid", 16'(dvO), 16'(!eO.ferr));
                checkOutput("odd.parity_err", 16'(peO), 16'(eO.perr));
                checkOutput("odd.frame_err", 16'(feO), 16'(eO.ferr));
                checkOutput("odd.data_out", 16'(doO), 16'(eO.data));
                checkOutput("odd.err_cnt", 16'(ecO), 16'(eO.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        bit_en   = 1'b0;
        rxE      = 1'b1;
        rxO      = 1'b1;
        lastData = 3'd0;
        expCnt   = 0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;

        $display("[TB] idle line");
        for (int i = 0; i < 5; i++) begin
            sendBit(1'b1, 1'b1, 1);
        end
        checkOutput("idle.even.busy", 16'(bsE), 16'd0);
        checkOutput("idle.odd.busy", 16'(bsO), 16'd0);

        $display("[TB] good frame, bad parity frame");
        applyStimulus(3'b101, 1'b0, 1'b1, 1);
        applyStimulus(3'b101, 1'b1, 1'b1, 1);

        $display("[TB] framing error then recovery");
        applyStimulus(3'b011, 1'b0, 1'b0, 1);
        applyStimulus(3'b111, 1'b1, 1'b1, 1);

        $display("[TB] slow strobe");
        applyStimulus(3'b110, 1'b0, 1'b1, 4);

        $display("[TB] reset mid-frame");
        sendBit(1'b0, 1'b0, 1);
        sendBit(1'b1, 1'b1, 1);
        sendBit(1'b0, 1'b0, 1);
        checkOutput("midFrame.even.busy", 16'(bsE), 16'd1);
        checkOutput("midFrame.odd.busy", 16'(bsO), 16'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        lastData = 3'd0;
        expCnt   = 0;
        checkResetState("midReset");
        applyStimulus(3'b001, 1'b1, 1'b1, 1);

        $display("[TB] sweep of data values with correct parity");
        for (int v = 0; v < 8; v++) begin
            logic [2:0] d;
            d = 3'(v);
            applyStimulus(d, ^d, 1'b1, 1);
        end

        repeat (4) @(posedge clk);
        #1;
        checkOutput("drain.even.queue", 16'(qE.size()), 16'd0);
        checkOutput("drain.odd.queue", 16'(qO.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
